uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 149 ++++++++++++++
 tb/tb_uart_rx.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver. Start bit, DATA_WIDTH data bits LSB-first,
// optional even/odd parity and one stop bit, each resolved by a mid-bit majority vote.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [5:0]            r_edge_cnt;
  logic [5:0]            r_prescale;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic [BCW-1:0]        r_bit_cnt;
  logic [2:0]            r_samp;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_data_valid;
  logic                  r_par_err;
  logic                  r_stp_err;

  logic [5:0]            w_mid;
  logic [5:0]            w_last;
  logic                  w_bit_end;
  logic                  w_bit;

  function automatic logic f_majority(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  function automatic logic f_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  assign w_mid     = {1'b0, r_prescale[5:1]};
  assign w_last    = r_prescale - 6'd1;
  assign w_bit_end = (r_edge_cnt == w_last);
  assign w_bit     = f_majority(r_samp);

  assign P_data     = r_p_data;
  assign data_valid = r_data_valid;
  assign par_err    = r_par_err;
  assign stp_err    = r_stp_err;

  // Edge counter and the three mid-bit samples; held at zero while idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_edge_cnt <= 6'd0;
      r_samp     <= 3'b111;
    end else if (r_state == S_IDLE) begin
      r_edge_cnt <= 6'd0;
    end else begin
      r_edge_cnt <= w_bit_end ? 6'd0 : r_edge_cnt + 6'd1;
      if (r_edge_cnt == w_mid - 6'd1) begin
        r_samp[0] <= RX_IN;
      end else if (r_edge_cnt == w_mid) begin
        r_samp[1] <= RX_IN;
      end else if (r_edge_cnt == w_mid + 6'd1) begin
        r_samp[2] <= RX_IN;
      end
    end
  end

  // Frame FSM: deserializer, parity/stop checks and the registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_prescale   <= 6'd0;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_bit_cnt    <= {BCW{1'b0}};
      r_shift      <= {DATA_WIDTH{1'b0}};
      r_p_data     <= {DATA_WIDTH{1'b0}};
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (RX_IN == 1'b0) begin
            r_state    <= S_START;
            r_prescale <= PRESCALE;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_par_err  <= 1'b0;
            r_stp_err  <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_bit_cnt <= {BCW{1'b0}};
            r_state   <= w_bit ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
            if (r_bit_cnt == BCW'(DATA_WIDTH - 1)) begin
              r_state <= r_par_en ? S_PARITY : S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + BCW'(1'b1);
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            if (w_bit != f_parity(r_shift, r_par_typ)) begin
              r_par_err <= 1'b1;
            end
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_state <= S_IDLE;
            if (w_bit == 1'b0) begin
              r_stp_err <= 1'b1;
            end else if (r_par_err == 1'b0) begin
              r_p_data     <= r_shift;
              r_data_valid <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a frame-level reference model
// (outcome from parity/stop rules, latency from the frame length).
module tb_uart_rx;
  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] PRESCALE;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [7:0] dv_data[$];
  int         dv_cyc[$];
  logic [7:0] last_good;

  always #5 CLK = ~CLK;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .P_data(P_data), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err)
  );

  // Record every data_valid cycle with its cycle stamp.
  always @(posedge CLK) begin
    #1;
    cyc = cyc + 1;
    if (data_valid === 1'b1) begin
      dv_data.push_back(P_data);
      dv_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: a frame is delivered iff stop is high and parity (if used) matches.
  function automatic bit exp_valid(input bit pen, input bit par_ok, input bit stop);
    return stop && (!pen || par_ok);
  endfunction

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive_frame(input logic [7:0] d, input int p, input bit pen, input bit typ,
                             input bit par_ok, input bit stop, output int t0);
    PRESCALE = 6'(p);
    PAR_EN   = pen;
    PAR_TYP  = typ;
    t0       = cyc;
    RX_IN    = 1'b0;
    repeat (p) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      repeat (p) @(negedge CLK);
    end
    if (pen) begin
      RX_IN = (^d) ^ typ ^ !par_ok;
      repeat (p) @(negedge CLK);
    end
    RX_IN = stop;
    repeat (p) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; RX_IN = 1'b1; PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(negedge CLK);
    n_vec++;
    if ({P_data, data_valid, par_err, stp_err} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 000", {P_data, data_valid, par_err, stp_err});
    end
    RST = 1'b0;
    last_good = 8'h00;
    idle(4);
  endtask

  task automatic test_parity_even();
    int t0;
    dv_data.delete(); dv_cyc.delete();
    drive_frame(8'h2A, 8, 1'b1, 1'b0, 1'b1, 1'b1, t0);
    idle(1);
    n_vec++;
    if ({par_err, stp_err} !== 2'b00) begin
      n_err++; $display("FAIL even_flags: got %b expected 00", {par_err, stp_err});
    end
    idle(3);
    n_vec++;
    if (dv_data.size() != 1) begin
      n_err++; $display("FAIL even_dv_count: got %0d expected 1", dv_data.size());
    end else begin
      n_vec++;
      if (dv_data[0] !== 8'h2A) begin
        n_err++; $display("FAIL even_data: got %h expected 2a", dv_data[0]);
      end
      n_vec++;
      if (dv_cyc[0] - t0 < 11 * 8 + 1 || dv_cyc[0] - t0 > 11 * 8 + 2) begin
        n_err++; $display("FAIL even_latency: got %0d expected %0d..%0d", dv_cyc[0] - t0, 89, 90);
      end
    end
    last_good = 8'h2A;
  endtask

  task automatic test_parity_odd();
    int t0;
    dv_data.delete(); dv_cyc.delete();
    drive_frame(8'h8E, 8, 1'b1, 1'b1, 1'b1, 1'b1, t0);
    idle(4);
    n_vec++;
    if (dv_data.size() != 1 || P_data !== 8'h8E || par_err !== 1'b0) begin
      n_err++; $display("FAIL odd_good: got dv=%0d data=%h perr=%b expected 1 8e 0",
                        dv_data.size(), P_data, par_err);
    end
    last_good = 8'h8E;
    dv_data.delete(); dv_cyc.delete();
    drive_frame(8'h8E, 8, 1'b1, 1'b1, 1'b0, 1'b1, t0);
    idle(4);
    n_vec++;
    if (dv_data.size() != 0 || par_err !== 1'b1 || stp_err !== 1'b0) begin
      n_err++; $display("FAIL odd_bad: got dv=%0d perr=%b serr=%b expected 0 1 0",
                        dv_data.size(), par_err, stp_err);
    end
    n_vec++;
    if (P_data !== last_good) begin
      n_err++; $display("FAIL odd_bad_hold: got %h expected %h", P_data, last_good);
    end
  endtask

  task automatic test_no_parity();
    int t0;
    dv_data.delete(); dv_cyc.delete();
    drive_frame(8'h0A, 8, 1'b0, 1'b0, 1'b1, 1'b1, t0);
    idle(4);
    n_vec++;
    if (dv_data.size() != 1 || P_data !== 8'h0A || par_err !== 1'b0) begin
      n_err++; $display("FAIL nopar_good: got dv=%0d data=%h perr=%b expected 1 0a 0",
                        dv_data.size(), P_data, par_err);
    end else begin
      n_vec++;
      if (dv_cyc[0] - t0 < 81 || dv_cyc[0] - t0 > 82) begin
        n_err++; $display("FAIL nopar_latency: got %0d expected 81..82", dv_cyc[0] - t0);
      end
    end
    last_good = 8'h0A;
    dv_data.delete(); dv_cyc.delete();
    drive_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    idle(4);
    n_vec++;
    if (dv_data.size() != 0 || stp_err !== 1'b1 || P_data !== last_good) begin
      n_err++; $display("FAIL nopar_stop_err: got dv=%0d serr=%b data=%h expected 0 1 %h",
                        dv_data.size(), stp_err, P_data, last_good);
    end
  endtask

  task automatic test_back_to_back();
    int ta, tb;
    dv_data.delete(); dv_cyc.delete();
    drive_frame(8'h0A, 8, 1'b0, 1'b0, 1'b1, 1'b1, ta);
    drive_frame(8'h8E, 8, 1'b0, 1'b0, 1'b1, 1'b1, tb);
    idle(4);
    n_vec++;
    if (dv_data.size() != 2) begin
      n_err++; $display("FAIL b2b_count: got %0d expected 2", dv_data.size());
    end else begin
      n_vec++;
      if (dv_data[0] !== 8'h0A || dv_data[1] !== 8'h8E) begin
        n_err++; $display("FAIL b2b_data: got %h %h expected 0a 8e", dv_data[0], dv_data[1]);
      end
      n_vec++;
      if (dv_cyc[1] - tb < 81 || dv_cyc[1] - tb > 82) begin
        n_err++; $display("FAIL b2b_latency: got %0d expected 81..82", dv_cyc[1] - tb);
      end
    end
    dv_data.delete(); dv_cyc.delete();
    drive_frame(8'h33, 8, 1'b0, 1'b0, 1'b1, 1'b0, ta);
    drive_frame(8'h5C, 8, 1'b0, 1'b0, 1'b1, 1'b1, tb);
    idle(4);
    n_vec++;
    if (dv_data.size() != 1 || P_data !== 8'h5C || stp_err !== 1'b0) begin
      n_err++; $display("FAIL stop_low_restart: got dv=%0d data=%h serr=%b expected 1 5c 0",
                        dv_data.size(), P_data, stp_err);
    end
    last_good = 8'h5C;
  endtask

  task automatic test_glitch();
    dv_data.delete(); dv_cyc.delete();
    PRESCALE = 6'd8; PAR_EN = 1'b0;
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    idle(12);
    n_vec++;
    if (dv_data.size() != 0 || {par_err, stp_err} !== 2'b00 || P_data !== last_good) begin
      n_err++; $display("FAIL glitch: got dv=%0d flags=%b data=%h expected 0 00 %h",
                        dv_data.size(), {par_err, stp_err}, P_data, last_good);
    end
  endtask

  task automatic test_reset_mid_frame();
    int t0;
    dv_data.delete(); dv_cyc.delete();
    PRESCALE = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    RX_IN = 1'b0;
    repeat (16) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (40) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    n_vec++;
    if ({P_data, data_valid, par_err, stp_err} !== 11'd0) begin
      n_err++; $display("FAIL reset_mid_frame: got %h expected 000", {P_data, data_valid, par_err, stp_err});
    end
    RST = 1'b0;
    last_good = 8'h00;
    idle(8);
    for (int k = 0; k < 2; k++) begin
      int p;
      p = (k == 0) ? 16 : 32;
      dv_data.delete(); dv_cyc.delete();
      drive_frame(8'h55, p, 1'b1, 1'b0, 1'b1, 1'b1, t0);
      idle(4);
      n_vec++;
      if (dv_data.size() != 1 || P_data !== 8'h55) begin
        n_err++; $display("FAIL after_reset_p%0d: got dv=%0d data=%h expected 1 55", p, dv_data.size(), P_data);
      end else begin
        n_vec++;
        if (dv_cyc[0] - t0 < 11 * p + 1 || dv_cyc[0] - t0 > 11 * p + 2) begin
          n_err++; $display("FAIL after_reset_lat_p%0d: got %0d expected %0d..%0d",
                            p, dv_cyc[0] - t0, 11 * p + 1, 11 * p + 2);
        end
      end
    end
    last_good = 8'h55;
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      int p, t0, lo;
      bit pen, typ, par_ok, stop, ev;
      d      = 8'($urandom);
      pen    = 1'($urandom);
      typ    = 1'($urandom);
      par_ok = ($urandom_range(0, 3) != 0);
      stop   = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 2))
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      ev = exp_valid(pen, par_ok, stop);
      lo = (10 + int'(pen)) * p + 1;
      dv_data.delete(); dv_cyc.delete();
      drive_frame(d, p, pen, typ, par_ok, stop, t0);
      idle(1);
      n_vec++;
      if ({par_err, stp_err} !== {pen && !par_ok, !stop}) begin
        n_err++; $display("FAIL rnd%0d_flags: got %b expected %b", n, {par_err, stp_err}, {pen && !par_ok, !stop});
      end
      idle($urandom_range(2, 4));
      if (ev) last_good = d;
      n_vec++;
      if (dv_data.size() != int'(ev) || P_data !== last_good) begin
        n_err++; $display("FAIL rnd%0d_data: got dv=%0d data=%h expected %0d %h",
                          n, dv_data.size(), P_data, int'(ev), last_good);
      end else if (ev) begin
        n_vec++;
        if (dv_cyc[0] - t0 < lo || dv_cyc[0] - t0 > lo + 1) begin
          n_err++; $display("FAIL rnd%0d_latency: got %0d expected %0d..%0d", n, dv_cyc[0] - t0, lo, lo + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_parity_even();
    test_parity_odd();
    test_no_parity();
    test_back_to_back();
    test_glitch();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
